// File: rtl/spatz_xif_offloader_if.sv
// Offload interface bundle for spatz_xif_offloader.
// Groups the core request, coprocessor issue/result, register-file
// writeback, status and performance-counter signals.
// The slave modport is the offloader's view; the master modport is the
// surrounding core/coprocessor environment.
interface spatz_xif_if #(
  parameter int IdWidth = 2
);
  // Core offload request
  logic               instr_valid_i;
  logic               instr_ready_o;
  logic [31:0]        instr_i;
  logic [31:0]        rs1_i;
  logic [31:0]        rs2_i;
  logic [4:0]         rd_i;
  // Coprocessor issue
  logic               x_issue_valid_o;
  logic               x_issue_ready_i;
  logic [31:0]        x_issue_instr_o;
  logic [31:0]        x_issue_rs1_o;
  logic [31:0]        x_issue_rs2_o;
  logic [IdWidth-1:0] x_issue_id_o;
  logic               x_issue_accept_i;
  logic               x_issue_writeback_i;
  // Coprocessor result
  logic               x_result_valid_i;
  logic               x_result_ready_o;
  logic [IdWidth-1:0] x_result_id_i;
  logic [31:0]        x_result_data_i;
  logic               x_result_we_i;
  // Register-file writeback
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [4:0]         wb_rd_o;
  logic [31:0]        wb_data_o;
  // Status and counters
  logic [31:0]        rd_busy_o;
  logic               illegal_o;
  logic               err_o;
  logic [15:0]        issued_cnt_o;
  logic [15:0]        rejected_cnt_o;

  modport slave (
    input  instr_valid_i, instr_i, rs1_i, rs2_i, rd_i,
    output instr_ready_o,
    output x_issue_valid_o, x_issue_instr_o, x_issue_rs1_o, x_issue_rs2_o, x_issue_id_o,
    input  x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
    input  x_result_valid_i, x_result_id_i, x_result_data_i, x_result_we_i,
    output x_result_ready_o,
    output wb_valid_o, wb_rd_o, wb_data_o,
    input  wb_ready_i,
    output rd_busy_o, illegal_o, err_o, issued_cnt_o, rejected_cnt_o
  );

  modport master (
    output instr_valid_i, instr_i, rs1_i, rs2_i, rd_i,
    input  instr_ready_o,
    input  x_issue_valid_o, x_issue_instr_o, x_issue_rs1_o, x_issue_rs2_o, x_issue_id_o,
    output x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
    output x_result_valid_i, x_result_id_i, x_result_data_i, x_result_we_i,
    input  x_result_ready_o,
    input  wb_valid_o, wb_rd_o, wb_data_o,
    output wb_ready_i,
    input  rd_busy_o, illegal_o, err_o, issued_cnt_o, rejected_cnt_o
  );
endinterface

// File: rtl/spatz_xif_offloader.sv
// spatz_xif_offloader: forwards core instructions to a coprocessor over an
// X-interface style issue/result protocol, tracks outstanding writebacks in
// a small id-indexed table, and returns results to the register file.
// Optional feature: define SPATZ_XIF_OFFLOADER_PERF_EN to enable the
// saturating issued/rejected performance counters.
module spatz_xif_offloader #(
  parameter int NumOutstanding = 4,
  parameter int IdWidth        = $clog2(NumOutstanding)
) (
  input logic        clk_i,
  input logic        rst_ni,
  spatz_xif_if.slave xif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]                state_q;
  logic                      live_q;
  logic [NumOutstanding-1:0] alloc_q, alloc_set, alloc_clr;
  logic [4:0]                rd_tab_q [NumOutstanding];
  logic [IdWidth-1:0]        free_idx;
  logic                      any_free;
  logic [31:0]               instr_q, rs1_q, rs2_q;
  logic [4:0]                rd_q;
  logic [IdWidth-1:0]        id_q;
  logic [31:0]               busy_q, busy_set, busy_clr;
  logic                      wb_valid_q;
  logic [4:0]                wb_rd_q;
  logic [31:0]               wb_data_q;
  logic                      illegal_q, err_q;
  logic                      instr_hs, issue_hs, result_hs, wb_hs, res_hit, alloc_en;

  assign instr_hs  = xif.instr_valid_i && xif.instr_ready_o;
  assign issue_hs  = xif.x_issue_valid_o && xif.x_issue_ready_i;
  assign result_hs = xif.x_result_valid_i && xif.x_result_ready_o;
  assign wb_hs     = wb_valid_q && xif.wb_ready_i;
  assign res_hit   = alloc_q[xif.x_result_id_i];
  assign alloc_en  = issue_hs && xif.x_issue_accept_i && xif.x_issue_writeback_i;

  // Lowest-index free table entry, from registered allocation state only.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NumOutstanding - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_idx = IdWidth'(i);
        any_free = 1'b1;
      end
    end
  end

  // Per-cycle set/clear masks for the entry table and the busy scoreboard.
  always_comb begin
    alloc_set = '0;
    alloc_clr = '0;
    busy_set  = '0;
    busy_clr  = '0;
    if (alloc_en) begin
      alloc_set[id_q] = 1'b1;
      if (rd_q != 5'd0) busy_set[rd_q] = 1'b1;
    end
    if (result_hs && res_hit) begin
      alloc_clr[xif.x_result_id_i] = 1'b1;
      // A result without register write never reaches the wb port, so release its busy bit here.
      if (!xif.x_result_we_i) busy_clr[rd_tab_q[xif.x_result_id_i]] = 1'b1;
    end
    if (wb_hs) busy_clr[wb_rd_q] = 1'b1;
  end

  // Request capture and IDLE/ISSUE sequencing.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      id_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      live_q    <= 1'b1;
      illegal_q <= issue_hs && !xif.x_issue_accept_i;
      case (state_q)
        IDLE: if (instr_hs) begin
          instr_q <= xif.instr_i;
          rs1_q   <= xif.rs1_i;
          rs2_q   <= xif.rs2_i;
          rd_q    <= xif.rd_i;
          id_q    <= free_idx;
          state_q <= ISSUE;
        end
        ISSUE: if (issue_hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Allocation table and busy scoreboard; a set wins over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q <= '0;
      busy_q  <= '0;
    end else begin
      alloc_q <= (alloc_q & ~alloc_clr) | alloc_set;
      busy_q  <= (busy_q & ~busy_clr) | busy_set;
    end
  end

  // Destination register per entry, qualified by alloc_q.
  // NOTE: this storage has no reset; alloc_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (alloc_en) rd_tab_q[id_q] <= rd_q;
  end

  // Single writeback output register plus the unknown-id error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= result_hs && !res_hit;
      if (result_hs && res_hit && xif.x_result_we_i) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= rd_tab_q[xif.x_result_id_i];
        wb_data_q  <= xif.x_result_data_i;
      end else if (wb_hs) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign xif.instr_ready_o    = live_q && (state_q == IDLE) && any_free;
  assign xif.x_issue_valid_o  = (state_q == ISSUE);
  assign xif.x_issue_instr_o  = instr_q;
  assign xif.x_issue_rs1_o    = rs1_q;
  assign xif.x_issue_rs2_o    = rs2_q;
  assign xif.x_issue_id_o     = id_q;
  assign xif.x_result_ready_o = live_q && (!wb_valid_q || xif.wb_ready_i);
  assign xif.wb_valid_o       = wb_valid_q;
  assign xif.wb_rd_o          = wb_rd_q;
  assign xif.wb_data_o        = wb_data_q;
  assign xif.rd_busy_o        = busy_q;
  assign xif.illegal_o        = illegal_q;
  assign xif.err_o            = err_q;

`ifdef SPATZ_XIF_OFFLOADER_PERF_EN
  logic [15:0] issued_q, rejected_q;

  // Saturating counters of accepted and rejected issues.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issued_q   <= '0;
      rejected_q <= '0;
    end else if (issue_hs) begin
      if (xif.x_issue_accept_i) begin
        if (issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      end else begin
        if (rejected_q != 16'hFFFF) rejected_q <= rejected_q + 16'd1;
      end
    end
  end

  assign xif.issued_cnt_o   = issued_q;
  assign xif.rejected_cnt_o = rejected_q;
`else
  assign xif.issued_cnt_o   = '0;
  assign xif.rejected_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spatz_xif_offloader.sv
// Directed bench for spatz_xif_offloader: a table of issue vectors with
// hand-computed ids/busy masks plus hand-written result/writeback sequences.
module tb_spatz_xif_offloader;
  localparam int NO = 4;
  localparam int IW = 2;
`ifdef SPATZ_XIF_OFFLOADER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  spatz_xif_if #(.IdWidth(IW)) xif ();

  spatz_xif_offloader #(.NumOutstanding(NO), .IdWidth(IW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .xif   (xif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]   instr;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [4:0]    rd;
    logic          accept;
    logic          wb;
    logic [IW-1:0] exp_id;
    logic          exp_ill;
    logic [31:0]   exp_busy;
  } issue_vec_t;

  issue_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait expired, got no handshake expected one", name);
  endtask

  // Called at a negedge; performs one instr + issue exchange.
  task automatic do_issue(input string tag, input logic [31:0] instr, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic accept,
                          input logic wb, input logic [IW-1:0] exp_id, input logic exp_ill);
    int n;
    n = 0;
    while (!xif.instr_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 20) timeout({tag, "/instr_ready"});
    xif.instr_valid_i = 1'b1;
    xif.instr_i       = instr;
    xif.rs1_i         = rs1;
    xif.rs2_i         = rs2;
    xif.rd_i          = rd;
    @(negedge clk_i);
    xif.instr_valid_i = 1'b0;
    check({tag, "/issue_valid"}, 32'(xif.x_issue_valid_o), 32'd1);
    check({tag, "/issue_instr"}, xif.x_issue_instr_o, instr);
    check({tag, "/issue_rs1"}, xif.x_issue_rs1_o, rs1);
    check({tag, "/issue_rs2"}, xif.x_issue_rs2_o, rs2);
    check({tag, "/issue_id"}, 32'(xif.x_issue_id_o), 32'(exp_id));
    check({tag, "/instr_ready_in_issue"}, 32'(xif.instr_ready_o), 32'd0);
    xif.x_issue_ready_i     = 1'b1;
    xif.x_issue_accept_i    = accept;
    xif.x_issue_writeback_i = wb;
    @(negedge clk_i);
    xif.x_issue_ready_i = 1'b0;
    check({tag, "/illegal"}, 32'(xif.illegal_o), 32'(exp_ill));
    check({tag, "/back_to_idle"}, 32'(xif.x_issue_valid_o), 32'd0);
  endtask

  // Called at a negedge; presents one result and returns at the negedge after its handshake.
  task automatic do_result(input string tag, input logic [IW-1:0] id, input logic [31:0] data,
                           input logic we);
    int n;
    n = 0;
    xif.x_result_valid_i = 1'b1;
    xif.x_result_id_i    = id;
    xif.x_result_data_i  = data;
    xif.x_result_we_i    = we;
    while (!xif.x_result_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 20) timeout({tag, "/result_ready"});
    @(negedge clk_i);
    xif.x_result_valid_i = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check({tag, "/wb_valid"}, 32'(xif.wb_valid_o), 32'd1);
    check({tag, "/wb_rd"}, 32'(xif.wb_rd_o), 32'(rd));
    check({tag, "/wb_data"}, xif.wb_data_o, data);
  endtask

  initial begin
    // Reject, no-writeback accept, then fill all four entries with rd 1..4.
    vecs[0] = '{32'h0000_0057, 32'h1, 32'h2, 5'd7, 1'b0, 1'b1, 2'd0, 1'b1, 32'h0000_0000};
    vecs[1] = '{32'h0200_0057, 32'h3, 32'h4, 5'd8, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0000};
    vecs[2] = '{32'h0C00_70D7, 32'h5, 32'h6, 5'd1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0002};
    vecs[3] = '{32'h0C00_7157, 32'h7, 32'h8, 5'd2, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_0006};
    vecs[4] = '{32'h0C00_71D7, 32'h9, 32'hA, 5'd3, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_000E};
    vecs[5] = '{32'h0C00_7257, 32'hB, 32'hC, 5'd4, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0000_001E};

    xif.instr_valid_i = 1'b0;  xif.instr_i = '0; xif.rs1_i = '0; xif.rs2_i = '0; xif.rd_i = '0;
    xif.x_issue_ready_i = 1'b0; xif.x_issue_accept_i = 1'b0; xif.x_issue_writeback_i = 1'b0;
    xif.x_result_valid_i = 1'b0; xif.x_result_id_i = '0; xif.x_result_data_i = '0;
    xif.x_result_we_i = 1'b0;   xif.wb_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst/instr_ready", 32'(xif.instr_ready_o), 32'd0);
    check("rst/result_ready", 32'(xif.x_result_ready_o), 32'd0);
    check("rst/issue_valid", 32'(xif.x_issue_valid_o), 32'd0);
    check("rst/wb_valid", 32'(xif.wb_valid_o), 32'd0);
    check("rst/busy", xif.rd_busy_o, 32'd0);
    check("rst/issued_cnt", 32'(xif.issued_cnt_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rel/instr_ready", 32'(xif.instr_ready_o), 32'd1);

    // Single vsetvli, rd=5, id 0, result 0x10
    do_issue("vset", 32'h0C05_72D7, 32'h20, 32'h0, 5'd5, 1'b1, 1'b1, 2'd0, 1'b0);
    check("vset/busy", xif.rd_busy_o, 32'h0000_0020);
    do_result("vset", 2'd0, 32'h10, 1'b1);
    expect_wb("vset", 5'd5, 32'h10);
    check("vset/busy_until_wb", xif.rd_busy_o, 32'h0000_0020);
    @(negedge clk_i);
    check("vset/wb_done", 32'(xif.wb_valid_o), 32'd0);
    check("vset/busy_clear", xif.rd_busy_o, 32'd0);

    // Table: reject, no-writeback accept, then four writeback issues
    for (int i = 0; i < 6; i++) begin
      do_issue($sformatf("vec%0d", i), vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
               vecs[i].accept, vecs[i].wb, vecs[i].exp_id, vecs[i].exp_ill);
      check($sformatf("vec%0d/busy", i), xif.rd_busy_o, vecs[i].exp_busy);
      @(negedge clk_i);
      check($sformatf("vec%0d/illegal_pulse_end", i), 32'(xif.illegal_o), 32'd0);
    end
    check("full/instr_ready", 32'(xif.instr_ready_o), 32'd0);
    check("perf/issued", 32'(xif.issued_cnt_o), PERF ? 32'd6 : 32'd0);
    check("perf/rejected", 32'(xif.rejected_cnt_o), PERF ? 32'd1 : 32'd0);

    // One result frees an entry; ready the following cycle
    do_result("free1", 2'd3, 32'h44, 1'b1);
    check("free1/instr_ready", 32'(xif.instr_ready_o), 32'd1);
    expect_wb("free1", 5'd4, 32'h44);

    // Out-of-order results 2,0,1
    do_result("ooo2", 2'd2, 32'h33, 1'b1);
    expect_wb("ooo2", 5'd3, 32'h33);
    do_result("ooo0", 2'd0, 32'h11, 1'b1);
    expect_wb("ooo0", 5'd1, 32'h11);
    do_result("ooo1", 2'd1, 32'h22, 1'b1);
    expect_wb("ooo1", 5'd2, 32'h22);
    @(negedge clk_i);
    check("ooo/busy_zero", xif.rd_busy_o, 32'd0);
    check("ooo/wb_idle", 32'(xif.wb_valid_o), 32'd0);

    // Result with an unallocated id
    do_result("badid", 2'd3, 32'hDEAD, 1'b1);
    check("badid/err", 32'(xif.err_o), 32'd1);
    check("badid/no_wb", 32'(xif.wb_valid_o), 32'd0);
    @(negedge clk_i);
    check("badid/err_pulse_end", 32'(xif.err_o), 32'd0);

    // Writeback backpressure with a second result waiting
    do_issue("bp0", 32'h0C00_7557, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1, 2'd0, 1'b0);
    do_issue("bp1", 32'h0C00_75D7, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 2'd1, 1'b0);
    check("bp/busy", xif.rd_busy_o, 32'h0000_0C00);
    xif.wb_ready_i       = 1'b0;
    xif.x_result_valid_i = 1'b1;
    xif.x_result_id_i    = 2'd0;
    xif.x_result_data_i  = 32'hAAAA_0001;
    xif.x_result_we_i    = 1'b1;
    @(negedge clk_i);
    xif.x_result_id_i   = 2'd1;
    xif.x_result_data_i = 32'hBBBB_0002;
    expect_wb("bp_first", 5'd10, 32'hAAAA_0001);
    check("bp/result_ready0", 32'(xif.x_result_ready_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check($sformatf("bp/stall%0d_ready", i), 32'(xif.x_result_ready_o), 32'd0);
      check($sformatf("bp/stall%0d_data", i), xif.wb_data_o, 32'hAAAA_0001);
    end
    xif.wb_ready_i = 1'b1;
    @(negedge clk_i);
    xif.x_result_valid_i = 1'b0;
    expect_wb("bp_second", 5'd11, 32'hBBBB_0002);
    check("bp/busy_mid", xif.rd_busy_o, 32'h0000_0800);
    @(negedge clk_i);
    check("bp/wb_done", 32'(xif.wb_valid_o), 32'd0);
    check("bp/busy_zero", xif.rd_busy_o, 32'd0);

    // Reset while in ISSUE with two entries allocated
    do_issue("rs0", 32'h0C00_7657, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1, 2'd0, 1'b0);
    do_issue("rs1", 32'h0C00_76D7, 32'h0, 32'h0, 5'd13, 1'b1, 1'b1, 2'd1, 1'b0);
    xif.instr_valid_i = 1'b1;
    xif.instr_i       = 32'h0C00_7757;
    xif.rd_i          = 5'd14;
    @(negedge clk_i);
    xif.instr_valid_i = 1'b0;
    check("rs/in_issue", 32'(xif.x_issue_valid_o), 32'd1);
    check("rs/issue_id", 32'(xif.x_issue_id_o), 32'd2);
    rst_ni = 1'b0;
    #1;
    check("rs/issue_valid", 32'(xif.x_issue_valid_o), 32'd0);
    check("rs/issue_instr", xif.x_issue_instr_o, 32'd0);
    check("rs/busy", xif.rd_busy_o, 32'd0);
    check("rs/instr_ready", 32'(xif.instr_ready_o), 32'd0);
    check("rs/result_ready", 32'(xif.x_result_ready_o), 32'd0);
    check("rs/issued_cnt", 32'(xif.issued_cnt_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rs/rel_instr_ready", 32'(xif.instr_ready_o), 32'd1);
    check("rs/rel_issue_valid", 32'(xif.x_issue_valid_o), 32'd0);
    do_issue("rs_after", 32'h0C00_77D7, 32'h0, 32'h0, 5'd15, 1'b1, 1'b1, 2'd0, 1'b0);
    check("rs_after/busy", xif.rd_busy_o, 32'h0000_8000);
    check("rs_after/issued", 32'(xif.issued_cnt_o), PERF ? 32'd1 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end
endmodule

// File: doc/spatz_xif_offloader.md
SPATZ_XIF_OFFLOADER -- requirements
Module: spatz_xif_offloader

Interface
REQ-001 SHALL have parameter NumOutstanding, default 4, giving the maximum number of accepted instructions awaiting a result (power of 2, 2..8).
REQ-002 SHALL have parameter IdWidth, default $clog2(NumOutstanding), giving the X-interface id width.
REQ-003 clk_i  in  1  clock; all state on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 instr_valid_i / instr_ready_o  in/out  1/1  core offload request handshake.
REQ-006 instr_i, rs1_i, rs2_i  in  32 each  instruction word and operand values.
REQ-007 rd_i  in  5  destination register index.
REQ-008 x_issue_valid_o / x_issue_ready_i  out/in  1/1  coprocessor issue handshake.
REQ-009 x_issue_instr_o, x_issue_rs1_o, x_issue_rs2_o  out  32 each  registered request payload.
REQ-010 x_issue_id_o  out  IdWidth  id of the issued request.
REQ-011 x_issue_accept_i, x_issue_writeback_i  in  1/1  issue response, valid on the issue handshake.
REQ-012 x_result_valid_i / x_result_ready_o  in/out  1/1  result handshake.
REQ-013 x_result_id_i  in  IdWidth;  x_result_data_i  in  32;  x_result_we_i  in  1.
REQ-014 wb_valid_o / wb_ready_i  out/in  1/1  register-file writeback handshake.
REQ-015 wb_rd_o  out  5;  wb_data_o  out  32  writeback target and data.
REQ-016 rd_busy_o  out  32  one bit per integer register with a pending writeback.
REQ-017 illegal_o  out  1  one-cycle pulse when the coprocessor rejects a request.
REQ-018 err_o  out  1  one-cycle pulse when a result arrives with an unallocated id.
REQ-019 issued_cnt_o, rejected_cnt_o  out  16 each  performance counters.

Function
REQ-020 The FSM SHALL have two states: IDLE and ISSUE.
REQ-021 In IDLE, instr_ready_o SHALL be 1 iff at least one table entry is free, judged on registered state only.
REQ-022 On an instr handshake, the block SHALL register instr/rs1/rs2/rd, set x_issue_id_o to the lowest free entry index, and move to ISSUE.
REQ-023 In ISSUE, x_issue_valid_o SHALL be 1, the payload SHALL be stable, and instr_ready_o SHALL be 0; issue latency from the instr handshake is 1 cycle.
REQ-024 On an issue handshake with accept=1 and writeback=1, the block SHALL allocate entry[id] holding rd, and SHALL set rd_busy_o[rd] unless rd=0; the FSM SHALL return to IDLE.
REQ-025 On an issue handshake with accept=1 and writeback=0, no entry SHALL be allocated; the FSM SHALL return to IDLE.
REQ-026 On an issue handshake with accept=0, illegal_o SHALL pulse on the next cycle, nothing SHALL be allocated, and the FSM SHALL return to IDLE.
REQ-027 x_result_ready_o SHALL equal !wb_valid_o || wb_ready_i (single output register).
REQ-028 On a result handshake whose id is allocated, the entry SHALL be freed in the same cycle; if we=1, the block SHALL load wb_valid_o=1, wb_rd_o=entry.rd and wb_data_o=data on the next cycle. Result-to-writeback latency is 1 cycle.
REQ-029 On a result handshake whose id is not allocated, the result SHALL be dropped and err_o SHALL pulse the next cycle.
REQ-030 rd_busy_o[wb_rd_o] SHALL clear on the wb handshake; a same-cycle set and clear of the same bit SHALL resolve to set.
REQ-031 Allocation and free of different entries in the same cycle SHALL both take effect; an entry freed in a cycle SHALL NOT be reported free until the next cycle.
REQ-032 Results MAY arrive in any id order; every accepted writeback instruction SHALL produce exactly one wb transaction.

Reset
REQ-033 While rst_ni=0, the block SHALL hold: FSM=IDLE, all entries free, rd_busy_o=0, all valid/ready/pulse outputs 0, payload outputs 0, counters 0; instructions in flight are discarded.
REQ-034 instr_ready_o SHALL go to 1 in the first cycle after reset release.

Configuration
REQ-035 With SPATZ_XIF_OFFLOADER_PERF_EN defined, issued_cnt_o SHALL count accepted issues and rejected_cnt_o SHALL count rejected issues; both SHALL saturate at 16'hFFFF.
REQ-036 Without SPATZ_XIF_OFFLOADER_PERF_EN, both counter outputs SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-037 Single vsetvli, rd=5, accept=1, writeback=1, id 0; result data 32'h10 one cycle later -> rd_busy_o[5]=1 until a wb with rd=5, data 32'h10.
REQ-038 Four accepted writeback issues with no results -> instr_ready_o=0; one result -> instr_ready_o=1 the cycle after.
REQ-039 Results returned in id order 2,0,1 -> three wb transactions with the matching rd values; rd_busy_o=0 at the end.
REQ-040 accept=0 on an issue -> illegal_o pulse, no busy bit set, rejected_cnt_o=1 (PERF_EN).
REQ-041 wb_ready_i=0 for 5 cycles with a second result pending -> x_result_ready_o=0 and no data lost.
REQ-042 Reset asserted while in ISSUE with two entries allocated -> all outputs 0 and instr_ready_o=1 after release.
